mul_arbiter: RTL and testbench

//  Shares one shift-add multiplier (St/Done/Idle handshake, W x W -> 2W) between NREQ requesters.

---
 rtl/mul_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mul_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Shares one shift-add multiplier (St/Done/Idle handshake, W x W -> 2W)
//   between NREQ requesters. Grant is round-robin. The winner's operands are
//   latched and the multiplier is given a one-cycle start pulse. The block then
//   waits for Done, bounded by TIMEOUT cycles. The product, or an error
//   response on timeout, comes back tagged with the requester id.
//
// Ports
//   Clk        clock, rising edge
//   Rst        synchronous reset, active-low
//   req        per-requester request level
//   op_a/op_b  packed operands, requester i at [i*W +: W]
//   busy       1 whenever the arbiter is not idle
//   rsp_valid  one-cycle response qualifier
//   rsp_id     requester owning the response
//   rsp_data   full 2*W product (0 on error)
//   rsp_err    multiply timed out
//   mul_st     start pulse to the multiplier
//   mul_a/b    latched operands to the multiplier
//   mul_done   multiplier Done (mul_prod valid while high)
//   mul_idle   multiplier Idle
//   mul_prod   multiplier product
// ---------------------------------------------------------------------------
module mul_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   op_a,
  input  logic [NREQ*W-1:0]   op_b,
  output logic                busy,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_data,
  output logic                rsp_err,
  output logic                mul_st,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic                mul_done,
  input  logic                mul_idle,
  input  logic [2*W-1:0]      mul_prod
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  grant_id_s;
  logic            grant_vld_s;
  logic [CW-1:0]   cnt_r;
  logic            timeout_s;

  logic            busy_s;
  logic            mul_st_s;
  logic            rsp_valid_s;

  logic            busy_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [2*W-1:0]  rsp_data_r;
  logic            rsp_err_r;
  logic            mul_st_r;
  logic [W-1:0]    mul_a_r;
  logic [W-1:0]    mul_b_r;

  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign mul_st    = mul_st_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

  // Limit reached in the current WAIT cycle; a simultaneous mul_done still wins.
  assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));

  // Round-robin winner search.
  // Candidates are scanned from the farthest (ptr+NREQ) to the nearest (ptr+1),
  // so the last hit is the highest-priority requester.
  always_comb begin
    int idx;
    grant_vld_s = |req;
    grant_id_s  = {IDW{1'b0}};
    idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(ptr_r) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      grant_id_s = req[idx] ? IDW'(idx) : grant_id_s;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_vld_s && mul_idle) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (mul_done || timeout_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode.
  // The decode works on the next state so that the registered flags line up
  // with the state they describe.
  always_comb begin
    busy_s      = (state_nxt_s != S_IDLE);
    mul_st_s    = (state_nxt_s == S_ISSUE);
    rsp_valid_s = (state_nxt_s == S_RESP);
  end

  // Registered outputs, operand latch, timeout counter and rr pointer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_data_r  <= {(2*W){1'b0}};
      rsp_err_r   <= 1'b0;
      mul_st_r    <= 1'b0;
      mul_a_r     <= {W{1'b0}};
      mul_b_r     <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      ptr_r       <= IDW'(NREQ - 1);
    end else begin
      busy_r      <= busy_s;
      mul_st_r    <= mul_st_s;
      rsp_valid_r <= rsp_valid_s;
      case (state_r)
        S_IDLE: begin
          if (grant_vld_s && mul_idle) begin
            mul_a_r  <= op_a[grant_id_s*W +: W];
            mul_b_r  <= op_b[grant_id_s*W +: W];
            rsp_id_r <= grant_id_s;
          end
        end
        S_ISSUE: cnt_r <= {CW{1'b0}};
        S_WAIT: begin
          if (mul_done) begin
            rsp_data_r <= mul_prod;
            rsp_err_r  <= 1'b0;
          end else if (timeout_s) begin
            rsp_data_r <= {(2*W){1'b0}};
            rsp_err_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        // The requester just served becomes lowest priority.
        S_RESP:  ptr_r <= rsp_id_r;
        default: ptr_r <= ptr_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int NREQ    = 2;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 1;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] op_a = '0;
  logic [NREQ*W-1:0] op_b = '0;
  logic              busy, rsp_valid, rsp_err, mul_st;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_done = 1'b0;
  logic              mul_idle;
  logic [2*W-1:0]    mul_prod = '0;

  mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .op_a(op_a), .op_b(op_b),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mul_st(mul_st), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_idle(mul_idle), .mul_prod(mul_prod)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier environment model ----------------
  logic        m_idle = 1'b1;
  logic        force_low = 1'b0;
  bit          mul_hang = 1'b0;
  int          lat_fix = 0;
  int          m_cnt = 0;
  logic [15:0] m_a, m_b;
  assign mul_idle = m_idle & ~force_low;

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (!Rst) begin
        m_idle = 1'b1; mul_done = 1'b0; mul_prod = '0; m_cnt = 0;
      end else begin
        if (mul_done) begin
          mul_done = 1'b0; mul_prod = '0; m_idle = 1'b1;
        end
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            mul_done = 1'b1;
            mul_prod = m_a * m_b;
          end
        end
        if (mul_st && !mul_hang) begin
          m_a = {8'd0, mul_a};
          m_b = {8'd0, mul_b};
          m_idle = 1'b0;
          m_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 8));
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct { int id; int a; int b; bit err; } exp_t;
  exp_t exp_q[$];
  int   opa_v[NREQ];
  int   opb_v[NREQ];
  int   rem[NREQ];
  int   rr_last = NREQ - 1;   // requester served most recently

  // Requests are served one at a time and in FIFO order, so the last entry
  // pushed is the last one to be served.
  task automatic push_exp(input int id);
    exp_t e;
    e.id = id; e.a = opa_v[id]; e.b = opb_v[id]; e.err = mul_hang;
    exp_q.push_back(e);
    rr_last = id;
  endtask

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*W +: W] = W'(opa_v[i]);
      op_b[i*W +: W] = W'(opb_v[i]);
    end
  endtask

  // ---------------- monitor ----------------
  int  cyc = 0;
  int  st_cyc = 0;
  int  n_st = 0;
  bit  prev_st = 1'b0;
  bit  prev_done = 1'b0;

  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (Rst) begin
      if (mul_st) begin
        n_st++;
        st_cyc = cyc;
        chk("st_single_cycle", {31'd0, prev_st}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mul_st: got mul_st=1 expected no issue (t=%0t)", $time);
        end else begin
          chk("mul_a", {24'd0, mul_a}, exp_q[0].a);
          chk("mul_b", {24'd0, mul_b}, exp_q[0].b);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid id=%0d data=%0d expected none (t=%0t)",
                   rsp_id, rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, e.id);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_data", {16'd0, rsp_data}, e.err ? 32'd0 : e.a * e.b);
          if (e.err) chk("timeout_latency", cyc - st_cyc, TIMEOUT + 1);
          else       chk("rsp_after_done", {31'd0, prev_done}, 32'd1);
        end
      end
    end
    prev_st   = mul_st;
    prev_done = mul_done;
  end

  // ---------------- stimulus helpers ----------------
  // Requester side of the protocol: on a response, either drop the request or
  // re-issue with fresh operands.
  task automatic drain(input string tag, input int budget);
    bit fin = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (rsp_valid) begin
        int id = int'(rsp_id);
        if (rem[id] > 0) rem[id]--;
        if (rem[id] > 0) begin
          opa_v[id] = $urandom_range(0, 255);
          opb_v[id] = $urandom_range(0, 255);
          apply_ops();
          push_exp(id);
        end else begin
          req[id] = 1'b0;
        end
      end else if (req == '0 && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_budget: got not drained after %0d cycles expected drained", tag, budget);
      req = '0;
      exp_q.delete();
    end
  endtask

  task automatic serve(input string tag, input logic [NREQ-1:0] mask, input int nops);
    for (int i = 0; i < NREQ; i++) rem[i] = mask[i] ? nops : 0;
    begin
      int first = rr_last;
      for (int k = 1; k <= NREQ; k++) begin
        int i = (first + k) % NREQ;
        if (mask[i]) push_exp(i);
      end
    end
    apply_ops();
    req = mask;
    drain(tag, 400);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_id"},    {31'd0, rsp_id}, 32'd0);
    chk({tag, "_rsp_data"},  {16'd0, rsp_data}, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    chk({tag, "_mul_st"},    {31'd0, mul_st}, 32'd0);
    chk({tag, "_mul_a"},     {24'd0, mul_a}, 32'd0);
    chk({tag, "_mul_b"},     {24'd0, mul_b}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; req = '0;
    exp_q.delete();
    rr_last = NREQ - 1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st0;
    repeat (2) @(negedge Clk);
    chk_zero("reset");
    Rst = 1'b1;

    // T1 single request
    st0 = n_st;
    opa_v[0] = 13; opb_v[0] = 11; opa_v[1] = 0; opb_v[1] = 0;
    serve("t1", 2'b01, 1);
    chk("t1_st_pulses", n_st - st0, 1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // T2 tie straight after reset: requester 0 first
    do_reset();
    opa_v[0] = 3; opb_v[0] = 5; opa_v[1] = 7; opb_v[1] = 9;
    serve("t2", 2'b11, 1);

    // T3 both held with new operands after every response: strict alternation
    opa_v[0] = 200; opb_v[0] = 17; opa_v[1] = 1; opb_v[1] = 255;
    serve("t3", 2'b11, 3);

    // T4 timeout, then a full-range product
    mul_hang = 1'b1;
    opa_v[0] = 44; opb_v[0] = 55;
    serve("t4a", 2'b01, 1);
    mul_hang = 1'b0;
    opa_v[1] = 255; opb_v[1] = 255;
    serve("t4b", 2'b10, 1);

    // T5 reset while waiting on a slow multiply
    lat_fix = 30;
    opa_v[0] = 9; opb_v[0] = 9; rem[0] = 1;
    push_exp(0); apply_ops(); req = 2'b01;
    repeat (6) @(negedge Clk);
    chk("t5_busy_in_wait", {31'd0, busy}, 32'd1);
    Rst = 1'b0; req = '0;
    exp_q.delete();
    rr_last = NREQ - 1;
    @(negedge Clk);
    chk_zero("t5");
    Rst = 1'b1;
    lat_fix = 0;
    repeat (4) begin
      @(negedge Clk);
      chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    opa_v[0] = 0; opb_v[0] = 200;
    serve("t5", 2'b01, 1);

    // T6 multiplier not idle holds off the grant
    force_low = 1'b1;
    opa_v[0] = 21; opb_v[0] = 12; rem[0] = 1;
    push_exp(0); apply_ops(); req = 2'b01;
    repeat (5) begin
      @(negedge Clk);
      chk("t6_no_st", {31'd0, mul_st}, 32'd0);
      chk("t6_no_busy", {31'd0, busy}, 32'd0);
    end
    force_low = 1'b0;
    @(negedge Clk);
    chk("t6_grant", {31'd0, mul_st}, 32'd1);
    drain("t6", 200);

    // Random rounds: random requester subsets, repeat counts and operands
    for (int r = 0; r < 25; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        opa_v[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
        opb_v[i] = ($urandom_range(0, 7) == 0) ? 0   : int'($urandom_range(0, 255));
      end
      serve("rand", m, $urandom_range(1, 3));
    end

    repeat (3) @(negedge Clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
